// File: rtl/wired_reduce_pkg.sv
// Shared types for the wired reduce/accumulate block: reduction modes,
// controller states and the per-mode identity value.
package wired_reduce_pkg;

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_AOR = 2'b10,
    MODE_XOR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Identity is all-ones only for AND; every other mode idles at zero.
  function automatic logic ident_ones(input logic [1:0] mode);
    return (mode == MODE_AND);
  endfunction

endpackage

// File: rtl/wired_reduce_comb.sv
// Combinational per-beat reduction of the enabled channels with the
// selected wired function. Disabled channels contribute the mode identity.
module wired_reduce_comb
  import wired_reduce_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic [NCH*W-1:0] data_i,
  input  logic [NCH-1:0]   en_i,
  input  logic [1:0]       mode_i,
  output logic [W-1:0]     red_o
);

  always_comb begin
    red_o = {W{ident_ones(mode_i)}};
    case (mode_i)
      MODE_OR: begin
        for (int i = 0; i < NCH; i++) begin
          if (en_i[i]) red_o = red_o | data_i[i*W +: W];
        end
      end
      MODE_AND: begin
        for (int i = 0; i < NCH; i++) begin
          if (en_i[i]) red_o = red_o & data_i[i*W +: W];
        end
      end
      MODE_AOR: begin
        // A pair only contributes when both of its channels are enabled.
        for (int k = 0; k < NCH / 2; k++) begin
          if (en_i[2*k] && en_i[2*k+1]) begin
            red_o = red_o | (data_i[(2*k)*W +: W] & data_i[(2*k+1)*W +: W]);
          end
        end
      end
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (en_i[i]) red_o = red_o ^ data_i[i*W +: W];
        end
      end
    endcase
  end

endmodule

// File: rtl/wired_reduce_accum.sv
// Burst accumulator around wired_reduce_comb: folds per-beat reductions over
// a burst of L beats, then holds the result on a valid/ready output.
module wired_reduce_accum
  import wired_reduce_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [NCH*W-1:0]   in_data_i,
  input  logic [NCH-1:0]     ch_en_i,
  input  logic [1:0]         mode_i,
  input  logic [LEN_W-1:0]   burst_len_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [W-1:0]       out_data_o,
  output logic [LEN_W-1:0]   out_beats_o
);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [W-1:0]     acc_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [1:0]       red_mode;
  logic [W-1:0]     red;
  logic [W-1:0]     acc_d;
  logic [LEN_W-1:0] cnt_d;
  logic [LEN_W-1:0] len_d;
  logic             accept;

  function automatic logic [W-1:0] combine(input logic [W-1:0] a,
                                           input logic [W-1:0] r,
                                           input logic [1:0]   m);
    case (m)
      MODE_AND: combine = a & r;
      MODE_XOR: combine = a ^ r;
      default:  combine = a | r;
    endcase
  endfunction

  // The first beat reduces with the live mode; later beats use the latched one.
  assign red_mode = (state_q == IDLE) ? mode_i : mode_q;

  wired_reduce_comb #(
    .NCH (NCH),
    .W   (W)
  ) u_comb (
    .data_i (in_data_i),
    .en_i   (ch_en_i),
    .mode_i (red_mode),
    .red_o  (red)
  );

  assign accept = in_valid_i && in_ready_q;
  assign len_d  = (burst_len_i == '0) ? LEN_W'(1) : burst_len_i;
  assign cnt_d  = cnt_q + 1'b1;
  assign acc_d  = (state_q == IDLE) ? red : combine(acc_q, red, mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= MODE_OR;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            mode_q <= mode_i;
            len_q  <= len_d;
            acc_q  <= acc_d;
            cnt_q  <= LEN_W'(1);
            if (len_d == LEN_W'(1)) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d == len_q) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = acc_q;
  assign out_beats_o = cnt_q;

endmodule

// File: tb/tb_wired_reduce_accum.sv
// Directed bench for wired_reduce_accum: a driver pushes hand-computed
// results into a scoreboard queue, a monitor compares on every output cycle.
module tb_wired_reduce_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  ch_en;
  logic [1:0]  mode;
  logic [3:0]  burst_len;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_beats;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] beats;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  wired_reduce_accum #(.NCH(4), .W(8), .LEN_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .ch_en_i     (ch_en),
    .mode_i      (mode),
    .burst_len_i (burst_len),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_beats_o (out_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
  task automatic beat(input logic [31:0] d, input logic [3:0] en,
                      input logic [1:0] m, input logic [3:0] bl);
    int n;
    in_valid  = 1'b1;
    in_data   = d;
    ch_en     = en;
    mode      = m;
    burst_len = bl;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input logic [7:0] d, input logic [3:0] b);
    exp_t e;
    e.data  = d;
    e.beats = b;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every cycle with out_valid high is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q[0];
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_beats", 32'(out_beats), 32'(e.beats));
          check("in_ready_in_hold", 32'(in_ready), 32'd0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ch_en     = '0;
    mode      = '0;
    burst_len = '0;
    out_ready = 1'b1;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // OR single beat: 01|02|04|80
    expect_result(8'h87, 4'd1);
    beat(32'h80040201, 4'b1111, 2'b00, 4'd1);
    check("or_latency_valid", 32'(out_valid), 32'd1);

    // AND-OR: (FF&0F)|(F0&3C)
    expect_result(8'h3F, 4'd1);
    beat(32'h3CF00FFF, 4'b1111, 2'b10, 4'd1);
    // ch3 disabled removes the upper pair
    expect_result(8'h0F, 4'd1);
    beat(32'h3CF00FFF, 4'b0111, 2'b10, 4'd1);

    // AND burst of 3, ch3 (00) disabled
    expect_result(8'hF0, 4'd3);
    beat(32'h00F3F0FF, 4'b0111, 2'b01, 4'd3);
    beat(32'h00F3F0FF, 4'b0111, 2'b01, 4'd3);
    check("and_not_done_early", 32'(out_valid), 32'd0);
    beat(32'h00F3F0FF, 4'b0111, 2'b01, 4'd3);

    // XOR with input gaps and output backpressure; other channels masked
    expect_result(8'hFF, 4'd2);
    beat(32'h1122335A, 4'b0001, 2'b11, 4'd2);
    idle(3);
    out_ready = 1'b0;
    beat(32'h443322A5, 4'b0001, 2'b11, 4'd2);
    check("xor_valid", 32'(out_valid), 32'd1);
    idle(4);
    check("xor_still_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    idle(1);
    check("xor_released", 32'(out_valid), 32'd0);

    // burst_len=0 behaves as 1
    expect_result(8'h10, 4'd1);
    beat(32'h00000010, 4'b0001, 2'b00, 4'd0);
    check("len0_valid", 32'(out_valid), 32'd1);

    // All channels disabled in AND mode yields all-ones
    expect_result(8'hFF, 4'd1);
    beat(32'h12345678, 4'b0000, 2'b01, 4'd1);

    // Mode and length changes mid-burst are ignored: OR of 01,02 over 2 beats
    expect_result(8'h03, 4'd2);
    beat(32'h00000001, 4'b0001, 2'b00, 4'd2);
    beat(32'h00000002, 4'b0001, 2'b01, 4'd1);

    // Asynchronous reset in the middle of a 4-beat burst
    beat(32'h00000001, 4'b0001, 2'b00, 4'd4);
    beat(32'h00000002, 4'b0001, 2'b00, 4'd4);
    check("mid_acc_nonzero", 32'(out_data), 32'h03);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data", 32'(out_data), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst2", 32'(in_ready), 32'd1);
    expect_result(8'h11, 4'd1);
    beat(32'h00000011, 4'b0001, 2'b00, 4'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
